// File: rtl/word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
//
// Packs a framed byte stream into 32-bit words, first byte in [31:24].
// Each frame starts with an 8-byte header:
//   byte0:byte1  total frame length L (big-endian, header included)
//   byte2:byte3  stream id
//   bytes 4-7    sequence number
//   bytes 8..L-1 payload
// Frames whose length falls outside [MIN_LEN, MAX_LEN] are swallowed
// entirely: no word is emitted for them, frameDrop pulses for one cycle and
// the saturating dropCount is incremented.
//
// Ports
//   clk            rising-edge clock
//   reset_b        asynchronous active-low reset
//   byteIn         input byte
//   byteIn_val     byteIn is valid
//   byteIn_ready   byte is accepted this cycle (byteIn_val && byteIn_ready)
//   dataOut        packed output word
//   dataOut_val    dataOut is valid
//   dataOut_ready  downstream accepts dataOut
//   dataOut_last   dataOut is the final word of its frame
//   frameDrop      one-cycle pulse when an illegal header is seen
//   dropCount      number of dropped frames, saturating at 255
// ---------------------------------------------------------------------------
module word_packer #(
    parameter int MIN_LEN = 9,
    parameter int MAX_LEN = 45
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [7:0]  byteIn,
    input  logic        byteIn_val,
    output logic        byteIn_ready,
    output logic [31:0] dataOut,
    output logic        dataOut_val,
    input  logic        dataOut_ready,
    output logic        dataOut_last,
    output logic        frameDrop,
    output logic [7:0]  dropCount
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state_q,      state_d;
    logic [1:0]  lane_q,       lane_d;
    logic [31:0] acc_q,        acc_d;
    logic [15:0] bytes_left_q, bytes_left_d;
    logic [31:0] data_q,       data_d;
    logic        val_q,        val_d;
    logic        last_q,       last_d;
    logic        drop_q,       drop_d;
    logic [7:0]  cnt_q,        cnt_d;

    logic        accept;
    logic        xfer;
    logic        hdr_mode;
    logic        word_done;
    logic        word_last;
    logic [15:0] frame_len;
    logic [31:0] merged;

    // Insert a byte into the accumulator at the given lane (lane 0 = MSB).
    function automatic logic [31:0] place_byte(input logic [31:0] acc,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = acc;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    function automatic logic len_legal(input logic [15:0] len);
        return (len >= MIN_LEN_W) && (len <= MAX_LEN_W);
    endfunction

    // The input stalls only while a word is held waiting for the parser.
    assign byteIn_ready = !(val_q && !dataOut_ready);

    assign accept = byteIn_val && byteIn_ready;
    assign xfer   = val_q && dataOut_ready;

    // A DROP with nothing left to discard behaves like HDR, so the byte
    // arriving in that cycle is taken as byte0 of the next frame.
    assign hdr_mode  = (state_q == HDR) ||
                       ((state_q == DROP) && (bytes_left_q == 16'd0));

    // When byte3 arrives, bytes 0 and 1 are sitting in the top two lanes.
    assign frame_len = acc_q[31:16];
    assign merged    = place_byte(acc_q, lane_q, byteIn);

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        acc_d        = acc_q;
        bytes_left_d = bytes_left_q;
        data_d       = data_q;
        val_d        = val_q;
        last_d       = last_q;
        drop_d       = 1'b0;
        cnt_d        = cnt_q;
        word_done    = 1'b0;
        word_last    = 1'b0;

        if (hdr_mode) begin
            state_d = HDR;
            if (accept) begin
                case (lane_q)
                    2'd0: begin
                        // Fresh word: clear the lower lanes explicitly.
                        acc_d  = {byteIn, 24'd0};
                        lane_d = 2'd1;
                    end
                    2'd1: begin
                        acc_d        = merged;
                        bytes_left_d = {acc_q[31:24], byteIn} - 16'd2;
                        lane_d       = 2'd2;
                    end
                    2'd2: begin
                        acc_d        = merged;
                        bytes_left_d = bytes_left_q - 16'd1;
                        lane_d       = 2'd3;
                    end
                    default: begin
                        acc_d  = 32'd0;
                        lane_d = 2'd0;
                        if (len_legal(frame_len)) begin
                            // Header word goes out; L >= MIN_LEN keeps it non-final.
                            word_done    = 1'b1;
                            bytes_left_d = bytes_left_q - 16'd1;
                            state_d      = BODY;
                        end else begin
                            state_d      = DROP;
                            drop_d       = 1'b1;
                            cnt_d        = (cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
                            bytes_left_d = (frame_len <= 16'd4) ? 16'd0
                                                                : frame_len - 16'd4;
                        end
                    end
                endcase
            end
        end else if (state_q == BODY) begin
            if (accept) begin
                bytes_left_d = bytes_left_q - 16'd1;
                if (bytes_left_q == 16'd1) begin
                    word_done = 1'b1;
                    word_last = 1'b1;
                    acc_d     = 32'd0;
                    lane_d    = 2'd0;
                    state_d   = HDR;
                end else if (lane_q == 2'd3) begin
                    word_done = 1'b1;
                    acc_d     = 32'd0;
                    lane_d    = 2'd0;
                end else begin
                    acc_d  = merged;
                    lane_d = lane_q + 2'd1;
                end
            end
        end else begin
            // DROP with bytes still to discard.
            if (accept) begin
                bytes_left_d = bytes_left_q - 16'd1;
                if (bytes_left_q == 16'd1) begin
                    state_d = HDR;
                end
            end
        end

        // A completing byte can only be accepted when the output register
        // is empty or draining this cycle, so loading never overwrites.
        if (word_done) begin
            data_d = merged;
            val_d  = 1'b1;
            last_d = word_last;
        end else if (xfer) begin
            val_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= HDR;
            lane_q       <= 2'd0;
            acc_q        <= 32'd0;
            bytes_left_q <= 16'd0;
            data_q       <= 32'd0;
            val_q        <= 1'b0;
            last_q       <= 1'b0;
            drop_q       <= 1'b0;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            bytes_left_q <= bytes_left_d;
            data_q       <= data_d;
            val_q        <= val_d;
            last_q       <= last_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dataOut      = data_q;
    assign dataOut_val  = val_q;
    assign dataOut_last = last_q;
    assign frameDrop    = drop_q;
    assign dropCount    = cnt_q;

endmodule

// File: tb/tb_word_packer.sv
// ---------------------------------------------------------------------------
// tb_word_packer
//
// Directed frames are driven byte by byte; the expected output words are
// queued as each frame is issued and a free-running monitor pops and
// compares them whenever a word is transferred.
// ---------------------------------------------------------------------------
module tb_word_packer;

    logic        clk;
    logic        reset_b;
    logic [7:0]  byteIn;
    logic        byteIn_val;
    logic        byteIn_ready;
    logic [31:0] dataOut;
    logic        dataOut_val;
    logic        dataOut_ready;
    logic        dataOut_last;
    logic        frameDrop;
    logic [7:0]  dropCount;

    int vectors;
    int miscompares;
    int drops_seen;

    logic [32:0] exp_q[$];
    logic [7:0]  fr[$];

    word_packer #(.MIN_LEN(9), .MAX_LEN(45)) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .byteIn       (byteIn),
        .byteIn_val   (byteIn_val),
        .byteIn_ready (byteIn_ready),
        .dataOut      (dataOut),
        .dataOut_val  (dataOut_val),
        .dataOut_ready(dataOut_ready),
        .dataOut_last (dataOut_last),
        .frameDrop    (frameDrop),
        .dropCount    (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int  n;
        logic ok;
        byteIn     = b;
        byteIn_val = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = byteIn_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %h not accepted within %0d cycles", b, n);
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        byteIn_val = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_pending_words"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: scoreboard compare on transfer, plus backpressure checks.
    initial begin
        logic [32:0] held;
        logic        held_vld;
        logic [32:0] e;
        held_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                held_vld = 1'b0;
            end else begin
                if (frameDrop) drops_seen++;
                if (dataOut_val && dataOut_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_word: got %h last=%b, none expected",
                                 dataOut, dataOut_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({dataOut_last, dataOut} !== e) begin
                            miscompares++;
                            $display("FAIL word: got %h last=%b expected %h last=%b",
                                     dataOut, dataOut_last, e[31:0], e[32]);
                        end
                    end
                end
                if (dataOut_val && !dataOut_ready) begin
                    vectors++;
                    if (byteIn_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL byteIn_ready_stall: got %b expected 0", byteIn_ready);
                    end
                    if (held_vld) begin
                        vectors++;
                        if ({dataOut_last, dataOut} !== held) begin
                            miscompares++;
                            $display("FAIL hold_stable: got %h last=%b expected %h last=%b",
                                     dataOut, dataOut_last, held[31:0], held[32]);
                        end
                    end
                    held     = {dataOut_last, dataOut};
                    held_vld = 1'b1;
                end else begin
                    held_vld = 1'b0;
                end
            end
        end
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        drops_seen    = 0;
        reset_b       = 1'b0;
        byteIn        = 8'd0;
        byteIn_val    = 1'b0;
        dataOut_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_dataOut",      dataOut,             32'd0);
        chk("rst_dataOut_val",  32'(dataOut_val),    32'd0);
        chk("rst_dataOut_last", 32'(dataOut_last),   32'd0);
        chk("rst_frameDrop",    32'(frameDrop),      32'd0);
        chk("rst_dropCount",    32'(dropCount),      32'd0);
        chk("rst_byteIn_ready", 32'(byteIn_ready),   32'd1);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;

        // L=12 frame, ready held high.
        push_word(32'h000C0005, 1'b0);
        push_word(32'h00000007, 1'b0);
        push_word(32'hAABBCCDD, 1'b1);
        fr = '{8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07,
               8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(fr);
        drain("l12");

        // L=45 frame, payload 01..25h, last word is a single byte.
        fr = '{8'h00, 8'h2D, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
        for (int i = 1; i <= 37; i++) fr.push_back(8'(i));
        push_word(32'h002D0001, 1'b0);
        push_word(32'h00000002, 1'b0);
        for (int i = 0; i < 9; i++)
            push_word({8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)}, 1'b0);
        push_word(32'h25000000, 1'b1);
        send_frame(fr);
        drain("l45");

        // L=3 header dropped, immediately followed by a legal L=9 frame.
        fr = '{8'h00, 8'h03, 8'h00, 8'h01,
               8'h00, 8'h09, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'hEE};
        push_word(32'h00090003, 1'b0);
        push_word(32'h00000004, 1'b0);
        push_word(32'hEE000000, 1'b1);
        send_frame(fr);
        drain("short_drop");
        chk("short_drop_pulses", 32'(drops_seen), 32'd1);
        chk("short_drop_count",  32'(dropCount),  32'd1);

        // L=50 frame discarded (46 bytes after the header), then L=9.
        fr = '{8'h00, 8'h32, 8'h00, 8'h07};
        for (int i = 0; i < 46; i++) fr.push_back(8'(8'hC0 + i));
        fr.push_back(8'h00); fr.push_back(8'h09); fr.push_back(8'h00); fr.push_back(8'h08);
        fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h09);
        fr.push_back(8'h77);
        push_word(32'h00090008, 1'b0);
        push_word(32'h00000009, 1'b0);
        push_word(32'h77000000, 1'b1);
        send_frame(fr);
        drain("long_drop");
        chk("long_drop_pulses", 32'(drops_seen), 32'd2);
        chk("long_drop_count",  32'(dropCount),  32'd2);

        // Downstream stalls for 10 cycles while the header word is pending.
        fr = '{8'h00, 8'h0C, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h0A,
               8'h11, 8'h22, 8'h33, 8'h44};
        push_word(32'h000C0009, 1'b0);
        push_word(32'h0000000A, 1'b0);
        push_word(32'h11223344, 1'b1);
        fork
            send_frame(fr);
            begin
                repeat (2) @(posedge clk);
                #1;
                dataOut_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                dataOut_ready = 1'b1;
            end
        join
        drain("stall");

        // Reset asserted after byte 6 of an L=12 frame.
        fr = '{8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
        push_word(32'h000C0005, 1'b0);
        send_frame(fr);
        #2;
        reset_b = 1'b0;
        #1;
        chk("midrst_dataOut",      dataOut,           32'd0);
        chk("midrst_dataOut_val",  32'(dataOut_val),  32'd0);
        chk("midrst_dataOut_last", 32'(dataOut_last), 32'd0);
        chk("midrst_frameDrop",    32'(frameDrop),    32'd0);
        chk("midrst_dropCount",    32'(dropCount),    32'd0);
        chk("midrst_pending",      32'(exp_q.size()), 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #1;
        fr = '{8'h00, 8'h09, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h5A};
        push_word(32'h00090001, 1'b0);
        push_word(32'h00000002, 1'b0);
        push_word(32'h5A000000, 1'b1);
        send_frame(fr);
        drain("after_rst");
        chk("after_rst_dropCount", 32'(dropCount),  32'd0);
        chk("total_drop_pulses",   32'(drops_seen), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 9, meaning the smallest legal frame length in bytes, header included.
REQ-002 SHALL have parameter MAX_LEN, default 45, meaning the largest legal frame length in bytes (8 header + 37 payload).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port byteIn, input, 8 bits: frame byte from the upstream source.
REQ-006 SHALL have port byteIn_val, input, 1 bit: byteIn is valid.
REQ-007 SHALL have port byteIn_ready, output, 1 bit: the block accepts byteIn this cycle.
REQ-008 SHALL have port dataOut, output, 32 bits: packed word, first byte in [31:24].
REQ-009 SHALL have port dataOut_val, output, 1 bit: dataOut is valid.
REQ-010 SHALL have port dataOut_ready, input, 1 bit: the downstream parser accepts dataOut.
REQ-011 SHALL have port dataOut_last, output, 1 bit: dataOut is the final word of the frame.
REQ-012 SHALL have port frameDrop, output, 1 bit: one-cycle pulse when an illegal frame header is detected.
REQ-013 SHALL have port dropCount, output, 8 bits: number of frames dropped, saturating.

Function
REQ-014 SHALL treat a byte as accepted when byteIn_val and byteIn_ready are both 1 on a rising edge.
REQ-015 SHALL treat a word as transferred when dataOut_val and dataOut_ready are both 1 on a rising edge.
REQ-016 SHALL drive byteIn_ready = !(dataOut_val && !dataOut_ready), a combinational function of registered state and dataOut_ready.
REQ-017 SHALL parse the frame format: byte0:byte1 = total length L (big-endian, header included); byte2:byte3 = stream id; bytes 4-7 = sequence; bytes 8..L-1 = payload.
REQ-018 SHALL implement the state machine: HDR (collecting bytes 0-3) -> BODY (bytes 4..L-1) -> HDR, or HDR -> DROP -> HDR.
REQ-019 SHALL, in HDR, load bytesLeft (16 bits) = L - 2 when byte1 is accepted.
REQ-020 SHALL, when byte3 is accepted, go to BODY if MIN_LEN <= L <= MAX_LEN; otherwise go to DROP.
REQ-021 SHALL, on entering DROP, pulse frameDrop for exactly 1 cycle, increment dropCount (holding at 255), and emit no word for that frame, including the header.
REQ-022 SHALL, in DROP, discard L-4 further bytes and return to HDR; if L <= 4, it SHALL return to HDR the next cycle and discard nothing.
REQ-023 SHALL pack accepted bytes MSB-first into a 32-bit accumulator with a 2-bit lane index.
REQ-024 SHALL complete a word on the 4th lane or on the frame's final byte (bytesLeft reaching 0).
REQ-025 SHALL zero the unused low lanes of a partial final word.
REQ-026 SHALL load a completed word into the output register on the edge after the completing byte is accepted; dataOut_val rises that cycle (latency 1).
REQ-027 SHALL set dataOut_last = 1 only with the final word of a frame.
REQ-028 SHALL hold dataOut, dataOut_val and dataOut_last stable while dataOut_val = 1 and dataOut_ready = 0.
REQ-029 SHALL, on a cycle with a transfer and a simultaneous completing byte, load the new word and keep dataOut_val = 1 with no bubble.
REQ-030 SHALL decrement bytesLeft once per accepted byte after byte1; 16-bit arithmetic, no wrap, because length is range-checked before BODY.
REQ-031 SHALL start the next frame's HDR on the byte immediately following the final byte, with no idle cycle required.

Reset
REQ-032 SHALL, while reset_b = 0 (asynchronously), force: state HDR, lane 0, accumulator 0, bytesLeft 0, dataOut 0, dataOut_val 0, dataOut_last 0, frameDrop 0, dropCount 0.
REQ-033 SHALL abandon any partial frame on reset mid-operation; the first byte after reset release is byte0 of a new frame.

Verification
REQ-034 SHALL cover: frame L=12, bytes 00 0C 00 05 00 00 00 07 AA BB CC DD, ready held 1 -> words 000C0005, 00000007, AABBCCDD; last=1 on the third word only.
REQ-035 SHALL cover: L=45, payload bytes 01..25h -> 12 words; final word 25000000 with last=1.
REQ-036 SHALL cover: header 00 03 00 01 followed by a legal L=9 frame -> frameDrop pulses once, dropCount=1, no words for the bad frame, then 3 correct words for the L=9 frame.
REQ-037 SHALL cover: L=50 frame -> 46 bytes discarded, frameDrop once, dropCount increments; a following L=9 frame is packed correctly.
REQ-038 SHALL cover: dataOut_ready held 0 for 10 cycles mid-frame -> byteIn_ready=0 once a word is pending, dataOut stable, no byte lost or duplicated after release.
REQ-039 SHALL cover: reset_b asserted after byte 6 of an L=12 frame -> all outputs 0 immediately (asynchronous); a new L=9 frame after release packs correctly.
